// File: rtl/imem_hw_responder_pkg.sv
// Shared widths, constants and the index-width helper for the instruction-memory responder.
package imem_hw_responder_pkg;

  localparam int HW_W    = 16;
  localparam int FETCH_W = 32;
  localparam logic [FETCH_W-1:0] FAULT_DATA = 32'h0;

  // Bank index width; a one-entry bank still needs a one-bit index.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_hw_responder_if.sv
// Fetch and loader-write signal bundle between the prefetch side and the responder.
interface imem_hw_responder_if;
  import imem_hw_responder_pkg::*;

  // Handshake: there is no ready. A fetch is accepted at every clock edge where
  // mem_rq = 1, and its mem_data/rd_err are valid from that edge until the next
  // accepted fetch. A write is applied at every edge where wr_en = 1.
  logic               mem_rq;
  logic [31:0]        mem_addr;
  logic [FETCH_W-1:0] mem_data;
  logic               rd_err;
  logic               wr_en;
  logic [31:0]        wr_addr;
  logic [31:0]        wr_data;
  logic [3:0]         wr_strb;

  modport master (
    output mem_rq, mem_addr, wr_en, wr_addr, wr_data, wr_strb,
    input  mem_data, rd_err
  );

  modport slave (
    input  mem_rq, mem_addr, wr_en, wr_addr, wr_data, wr_strb,
    output mem_data, rd_err
  );

endinterface

// File: rtl/imem_bank16.sv
// One 16-bit halfword bank: byte-enable synchronous write, synchronous read with
// enable, and write-first bypass when both ports hit the same entry.
module imem_bank16
  import imem_hw_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic [HW_W-1:0] rd_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_idx,
  input  logic [HW_W-1:0] wr_data,
  input  logic [1:0]      wr_be
);

  logic [HW_W-1:0] mem [DEPTH];
  logic [HW_W-1:0] rd_next;

  // Freshly written bytes win on a same-entry collision; unstrobed bytes keep the old value.
  always_comb begin
    rd_next = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      if (wr_be[0]) rd_next[7:0]  = wr_data[7:0];
      if (wr_be[1]) rd_next[15:8] = wr_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_be[0]) mem[wr_idx][7:0]  <= wr_data[7:0];
      if (wr_be[1]) mem[wr_idx][15:8] <= wr_data[15:8];
    end
    if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/imem_hw_responder.sv
// Halfword-aligned fetch responder: reads even/odd banks in parallel and returns
// {halfword @A, halfword @A+2} one edge later, with a registered fault flag.
module imem_hw_responder
  import imem_hw_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                resetn,
  imem_hw_responder_if.slave  bus
);

  localparam int          AW   = idx_w(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0]     rd_off;
  logic [31:0]     wr_off;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   e_idx;
  logic [AW-1:0]   wr_idx;
  logic            h;
  logic            rd_fault;
  logic            rd_go;
  logic            wr_go;
  logic [HW_W-1:0] e_q;
  logic [HW_W-1:0] o_q;
  logic            sel_q;
  logic            ok_q;
  logic            err_q;

  // Requests and writes are gated by resetn so nothing touches the banks while reset is held.
  always_comb begin
    rd_off   = bus.mem_addr - BASE_ADDR;
    w_idx    = rd_off[AW+1:2];
    h        = rd_off[1];
    e_idx    = w_idx + AW'(h);
    rd_fault = bus.mem_addr[0] | (rd_off >= SPAN) | (rd_off == (SPAN - 32'd2));
    rd_go    = resetn & bus.mem_rq & ~rd_fault;
    wr_off   = bus.wr_addr - BASE_ADDR;
    wr_idx   = wr_off[AW+1:2];
    wr_go    = resetn & bus.wr_en & (wr_off < SPAN);
  end

  imem_bank16 #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_even (
    .clk     (clk),
    .rd_en   (rd_go),
    .rd_idx  (e_idx),
    .rd_data (e_q),
    .wr_en   (wr_go),
    .wr_idx  (wr_idx),
    .wr_data (bus.wr_data[15:0]),
    .wr_be   (bus.wr_strb[1:0])
  );

  imem_bank16 #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_odd (
    .clk     (clk),
    .rd_en   (rd_go),
    .rd_idx  (w_idx),
    .rd_data (o_q),
    .wr_en   (wr_go),
    .wr_idx  (wr_idx),
    .wr_data (bus.wr_data[31:16]),
    .wr_be   (bus.wr_strb[3:2])
  );

  // ok_q qualifies the bank outputs, so reset and faults force zero data without touching the banks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q <= 1'b0;
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.mem_rq) begin
      sel_q <= h & ~rd_fault;
      ok_q  <= ~rd_fault;
      err_q <= rd_fault;
    end
  end

  assign bus.mem_data = !ok_q ? FAULT_DATA : (sel_q ? {o_q, e_q} : {e_q, o_q});
  assign bus.rd_err   = err_q;

endmodule

// File: tb/tb_imem_hw_responder.sv
// Bench for imem_hw_responder: directed scenarios plus a randomized run checked
// against a byte-array memory model.
module tb_imem_hw_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          SPAN  = DEPTH * 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  imem_hw_responder_if bus();

  imem_hw_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [7:0]  mb [SPAN];
  logic [32:0] exp_q[$];
  logic [32:0] last_exp = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Expected {rd_err, mem_data} for a fetch at byte address a, from byte-level memory.
  function automatic logic [32:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    int          o;
    off = a - BASE;
    if (a[0] || off >= 32'(SPAN) || off == 32'(SPAN - 2)) return {1'b1, 32'h0};
    o = int'(off);
    return {1'b0, mb[o+1], mb[o], mb[o+3], mb[o+2]};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'(SPAN)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mb[int'({off[31:2], 2'b00}) + b] = d[8*b +: 8];
    end
  endfunction

  // One clock of stimulus; the model applies the write before the read (write-first).
  task automatic drive(input logic rq, input logic [31:0] addr, input logic we,
                       input logic [31:0] waddr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    @(negedge clk);
    bus.mem_rq   = rq;
    bus.mem_addr = addr;
    bus.wr_en    = we;
    bus.wr_addr  = waddr;
    bus.wr_data  = wdata;
    bus.wr_strb  = wstrb;
    @(posedge clk);
    if (resetn) begin
      if (we) model_write(waddr, wdata, wstrb);
      if (rq) last_exp = model_read(addr);
    end else begin
      last_exp = '0;
    end
    #1;
    bus.mem_rq = 1'b0;
    bus.wr_en  = 1'b0;
    exp_q.push_back(last_exp);
  endtask

  task automatic test_reset();
    logic [32:0] got;
    bus.mem_rq = 0; bus.mem_addr = 0; bus.wr_en = 0;
    bus.wr_addr = 0; bus.wr_data = 0; bus.wr_strb = 0;
    #2;
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", got, 33'h0);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 32'(i * 4), $urandom, 4'hF);
    drive(0, 0, 1, 32'h0, 32'h2222_1111, 4'hF);
    drive(0, 0, 1, 32'h4, 32'h4444_3333, 4'hF);
  endtask

  task automatic test_basic_reads();
    logic [31:0] addrs [3];
    logic [32:0] exps  [3];
    logic [32:0] got;
    addrs[0] = 32'h0; exps[0] = {1'b0, 32'h1111_2222};
    addrs[1] = 32'h2; exps[1] = {1'b0, 32'h2222_3333};
    addrs[2] = 32'h6; exps[2] = {1'b0, 16'h4444, mb[9], mb[8]};
    for (int i = 0; i < 3; i++) begin
      drive(1, addrs[i], 0, 0, 0, 0);
      got = {bus.rd_err, bus.mem_data};
      n_checks++;
      if (got !== exps[i]) begin
        n_fail++;
        $display("FAIL basic_read addr=%h: got %h expected %h", addrs[i], got, exps[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 0, 0, 0, 0);
      got = {bus.rd_err, bus.mem_data};
      n_checks++;
      if (got !== exps[2]) begin
        n_fail++;
        $display("FAIL idle_hold cycle=%0d: got %h expected %h", i, got, exps[2]);
      end
    end
  endtask

  task automatic test_collision();
    logic [32:0] got;
    drive(1, 32'h2, 1, 32'h4, 32'hAAAA_BBBB, 4'b0011);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b0, 32'h2222_BBBB}) begin
      n_fail++;
      $display("FAIL collision_read: got %h expected %h", got, {1'b0, 32'h2222_BBBB});
    end
    drive(1, 32'h4, 0, 0, 0, 0);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b0, 32'hBBBB_4444}) begin
      n_fail++;
      $display("FAIL after_collision: got %h expected %h", got, {1'b0, 32'hBBBB_4444});
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [7];
    logic [32:0] exps  [7];
    logic [32:0] got;
    addrs[0] = 32'hFFE;  exps[0] = {1'b1, 32'h0};
    addrs[1] = 32'h1000; exps[1] = {1'b1, 32'h0};
    addrs[2] = 32'h001;  exps[2] = {1'b1, 32'h0};
    addrs[3] = 32'h0;    exps[3] = {1'b0, 32'h1111_2222};
    addrs[4] = 32'hFFC;  exps[4] = model_read(32'hFFC);
    addrs[5] = 32'hFFA;  exps[5] = {1'b0, mb[4091], mb[4090], mb[4093], mb[4092]};
    addrs[6] = 32'hFFFF_FFFE; exps[6] = {1'b1, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drive(1, addrs[i], 0, 0, 0, 0);
      got = {bus.rd_err, bus.mem_data};
      n_checks++;
      if (got !== exps[i]) begin
        n_fail++;
        $display("FAIL fault_check addr=%h: got %h expected %h", addrs[i], got, exps[i]);
      end
    end
    drive(1, 32'h1000, 1, 32'h8, 32'h5566_7788, 4'hF);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL fault_with_write: got %h expected %h", got, {1'b1, 32'h0});
    end
    drive(0, 32'h0, 0, 0, 0, 0);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL fault_hold: got %h expected %h", got, {1'b1, 32'h0});
    end
    drive(1, 32'h8, 0, 0, 0, 0);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b0, 32'h7788_5566}) begin
      n_fail++;
      $display("FAIL write_during_fault: got %h expected %h", got, {1'b0, 32'h7788_5566});
    end
  endtask

  task automatic test_oob_write();
    logic [32:0] got;
    drive(0, 0, 1, 32'h1000, 32'h9999_9999, 4'hF);
    drive(0, 0, 1, 32'hFFFF_FFFC, 32'h9999_9999, 4'hF);
    drive(1, 32'h0, 0, 0, 0, 0);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b0, 32'h1111_2222}) begin
      n_fail++;
      $display("FAIL oob_write_w0: got %h expected %h", got, {1'b0, 32'h1111_2222});
    end
    drive(1, 32'h4, 0, 0, 0, 0);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b0, 32'hBBBB_4444}) begin
      n_fail++;
      $display("FAIL oob_write_w1: got %h expected %h", got, {1'b0, 32'hBBBB_4444});
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] got;
    drive(1, 32'h4, 0, 0, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== 33'h0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got %h expected %h", got, 33'h0);
    end
    drive(1, 32'h1000, 1, 32'h0, 32'h0BAD_0BAD, 4'hF);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_ignores_rq: got %h expected %h", got, 33'h0);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 32'h0, 0, 0, 0, 0);
    got = {bus.rd_err, bus.mem_data};
    n_checks++;
    if (got !== {1'b0, 32'h1111_2222}) begin
      n_fail++;
      $display("FAIL after_reset_read: got %h expected %h", got, {1'b0, 32'h1111_2222});
    end
  endtask

  task automatic test_random();
    logic        rq;
    logic        we;
    logic [31:0] addr;
    logic [31:0] waddr;
    logic [32:0] exp;
    logic [32:0] got;
    int          r;
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      r  = int'($urandom_range(0, 9));
      if (r < 7)       addr = 32'($urandom_range(0, SPAN / 2 - 1) * 2);
      else if (r == 7) addr = 32'($urandom_range(0, SPAN - 1)) | 32'h1;
      else if (r == 8) addr = 32'(SPAN - 2) + 32'($urandom_range(0, 3) * 2);
      else             addr = $urandom;
      we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1)
        waddr = (($urandom_range(0, 1) == 1) ? addr : addr + 32'd2) & ~32'h3;
      else
        waddr = 32'($urandom_range(0, DEPTH + 8) * 4) | 32'($urandom_range(0, 3));
      drive(rq, addr, we, waddr, $urandom, 4'($urandom_range(0, 15)));
      exp = exp_q.pop_front();
      got = {bus.rd_err, bus.mem_data};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random i=%0d rq=%b addr=%h: got %h expected %h", i, rq, addr, got, exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload();
    test_basic_reads();
    test_collision();
    test_faults();
    test_oob_write();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
